// File: rtl/unstriping_pkg.sv
// Shared constants and helpers for the two-lane unstriping stage.
package unstriping_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int NUM_LANES      = 2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Ceiling log2, used to size FIFO pointers and counts at elaboration.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/unstriping_if.sv
// Lane inputs and merged output / status bundle for the unstriping stage.
interface unstriping_if #(
  parameter int DATA_WIDTH = unstriping_pkg::DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] lane_0;
  logic                  valid_0;
  logic [DATA_WIDTH-1:0] lane_1;
  logic                  valid_1;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full_0;
  logic                  full_1;
  logic                  overflow_0;
  logic                  overflow_1;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, full_0, full_1, overflow_0, overflow_1
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, full_0, full_1, overflow_0, overflow_1
  );
endinterface

// File: rtl/unstriping_lane_fifo.sv
// Per-lane synchronous FIFO; head word is presented combinationally on dout.
module lane_fifo
  import unstriping_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  wr_en, rd_en;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/unstriping.sv
// Rebuilds the single word stream from two striped lanes, strictly alternating lane 0, lane 1.
module unstriping
  import unstriping_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic         clk_2f,
  input  logic         reset,
  unstriping_if.slave  bus
);
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_d, head;
  logic [NUM_LANES-1:0]                 lane_v, push, pop, full, empty, ovf;
  logic                                 sel;
  logic [DATA_WIDTH-1:0]                data_q;
  logic                                 valid_q;

  assign lane_d = {bus.lane_1, bus.lane_0};
  assign lane_v = {bus.valid_1, bus.valid_0};

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      // Only the lane sel points at may drain; the other lane waits its turn.
      assign pop[i]  = ~empty[i] & (sel == 1'(i));
      assign push[i] = lane_v[i] & (~full[i] | pop[i]);

      lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_fifo (
        .clk_2f (clk_2f),
        .reset  (reset),
        .push   (push[i]),
        .pop    (pop[i]),
        .din    (lane_d[i]),
        .dout   (head[i]),
        .full   (full[i]),
        .empty  (empty[i])
      );
    end
  endgenerate

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_v[i] && full[i] && !pop[i]) ovf[i] <= 1'b1;
    end
  end

  // Stall on an empty expected lane rather than skipping, so order is never broken.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel     <= LANE0;
    end else if (!empty[sel]) begin
      data_q  <= head[sel];
      valid_q <= 1'b1;
      sel     <= ~sel;
    end else begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.full_0     = full[LANE0];
  assign bus.full_1     = full[LANE1];
  assign bus.overflow_0 = ovf[LANE0];
  assign bus.overflow_1 = ovf[LANE1];
endmodule

// File: tb/tb_unstriping.sv
// Directed bench for unstriping: ordering, skew stall, overflow, push+pop on full, reset, idle.
module tb_unstriping;
  logic clk_2f = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  unstriping_if #(.DATA_WIDTH(32)) bus ();

  unstriping #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    bus.valid_0 = v0;
    bus.lane_0  = d0;
    bus.valid_1 = v1;
    bus.lane_1  = d1;
  endtask

  // Drive one cycle's lane inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    drive(v0, d0, v1, d1);
    @(posedge clk_2f);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic out(input string tag, input logic v, input logic [31:0] d);
    chk({tag, ".v"}, {31'b0, bus.valid_out}, {31'b0, v});
    chk({tag, ".d"}, bus.data_out, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk_2f); #1;
    do_reset();
    out("rst", 1'b0, 32'h0);
    chk("rst.full_0", {31'b0, bus.full_0}, 32'h0);
    chk("rst.full_1", {31'b0, bus.full_1}, 32'h0);
    chk("rst.ovf_0", {31'b0, bus.overflow_0}, 32'h0);
    chk("rst.ovf_1", {31'b0, bus.overflow_1}, 32'h0);

    // In-order stream, one word per cycle
    do_reset();
    cyc(1'b1, 32'hFFFFFFFF, 1'b0, 32'h0); out("t1.c1", 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'hEEEEEEEE); out("t1.c2", 1'b1, 32'hFFFFFFFF);
    cyc(1'b1, 32'hDDDDDDDD, 1'b0, 32'h0); out("t1.c3", 1'b1, 32'hEEEEEEEE);
    cyc(1'b0, 32'h0, 1'b1, 32'hCCCCCCCC); out("t1.c4", 1'b1, 32'hDDDDDDDD);
    idle();                               out("t1.c5", 1'b1, 32'hCCCCCCCC);
    idle();                               out("t1.c6", 1'b0, 32'h0);

    // Skew: lane 1 late, output stalls instead of skipping
    do_reset();
    cyc(1'b1, 32'h3, 1'b0, 32'h0); out("t2.c1", 1'b0, 32'h0);
    cyc(1'b1, 32'h5, 1'b0, 32'h0); out("t2.c2", 1'b1, 32'h3);
    idle();                        out("t2.c3", 1'b0, 32'h0);
    idle();                        out("t2.c4", 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 32'h4); out("t2.c5", 1'b0, 32'h0);
    idle();                        out("t2.c6", 1'b1, 32'h4);
    idle();                        out("t2.c7", 1'b1, 32'h5);
    idle();                        out("t2.c8", 1'b0, 32'h0);

    // Overflow on lane 0 while lane 1 is idle
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1'b1, 32'h100 + 32'(k), 1'b0, 32'h0);
    chk("t3.full_c4", {31'b0, bus.full_0}, 32'h0);
    cyc(1'b1, 32'h105, 1'b0, 32'h0);
    chk("t3.full_c5", {31'b0, bus.full_0}, 32'h1);
    chk("t3.ovf_c5", {31'b0, bus.overflow_0}, 32'h0);
    cyc(1'b1, 32'h106, 1'b0, 32'h0);
    chk("t3.ovf_c6", {31'b0, bus.overflow_0}, 32'h1);
    chk("t3.full_c6", {31'b0, bus.full_0}, 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 32'h201); out("t3.c7", 1'b0, 32'h0);
    chk("t3.ovf_c7", {31'b0, bus.overflow_0}, 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 32'h202); out("t3.c8", 1'b1, 32'h201);
    idle();                          out("t3.c9", 1'b1, 32'h102);
    chk("t3.full_c9", {31'b0, bus.full_0}, 32'h0);
    idle();                          out("t3.c10", 1'b1, 32'h202);
    idle();                          out("t3.c11", 1'b1, 32'h103);
    idle();                          out("t3.c12", 1'b0, 32'h0);

    // Push and pop on a full FIFO in the same cycle
    do_reset();
    cyc(1'b1, 32'hA1, 1'b0, 32'h0);
    cyc(1'b1, 32'hA2, 1'b0, 32'h0); out("t4.c2", 1'b1, 32'hA1);
    cyc(1'b1, 32'hA3, 1'b0, 32'h0);
    cyc(1'b1, 32'hA4, 1'b0, 32'h0);
    cyc(1'b1, 32'hA5, 1'b0, 32'h0);
    chk("t4.full_c5", {31'b0, bus.full_0}, 32'h1);
    cyc(1'b0, 32'h0, 1'b1, 32'hB1);
    idle();                         out("t4.c7", 1'b1, 32'hB1);
    cyc(1'b1, 32'hA6, 1'b0, 32'h0); out("t4.c8", 1'b1, 32'hA2);
    chk("t4.full_c8", {31'b0, bus.full_0}, 32'h1);
    chk("t4.ovf_c8", {31'b0, bus.overflow_0}, 32'h0);

    // Reset mid-operation discards stored words and the reset-cycle input
    do_reset();
    for (int k = 1; k <= 5; k++) cyc(1'b0, 32'h0, 1'b1, 32'hC0 + 32'(k));
    chk("t5.ovf1_pre", {31'b0, bus.overflow_1}, 32'h1);
    chk("t5.full1_pre", {31'b0, bus.full_1}, 32'h1);
    cyc(1'b1, 32'hD1, 1'b0, 32'h0);
    cyc(1'b1, 32'hD2, 1'b0, 32'h0); out("t5.pre", 1'b1, 32'hD1);
    reset = 1'b1;
    cyc(1'b1, 32'hAAAAAAAA, 1'b0, 32'h0);
    reset = 1'b0;
    out("t5.rst", 1'b0, 32'h0);
    chk("t5.ovf1", {31'b0, bus.overflow_1}, 32'h0);
    chk("t5.full1", {31'b0, bus.full_1}, 32'h0);
    chk("t5.full0", {31'b0, bus.full_0}, 32'h0);
    cyc(1'b1, 32'h5, 1'b0, 32'h0); out("t5.c1", 1'b0, 32'h0);
    idle();                        out("t5.c2", 1'b1, 32'h5);
    idle();                        out("t5.c3", 1'b0, 32'h0);

    // Idle after reset
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle();
      out($sformatf("t6.c%0d", k), 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
